arm7_wait_mem: RTL

//  Synthesizable single-port 32-bit memory slave for the arm7tdmi_top memory bus
//  (mem_addr/mem_we/mem_re/mem_be/mem_ready). Generalises the bench's ideal,

---
 rtl/arm7_wait_mem.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/arm7_wait_mem.sv
// Single-port 32-bit memory slave for the arm7tdmi_top bus with wait states, byte lanes, range fault, backdoor.
// Latency: request sampled at edge E0, mem_ready pulses for one cycle after edge E0+wait count (1+wait cycles).
// Backpressure: mem_ready withheld while waiting; master holds request stable until ready, then 2 edges gap.
//
// Ports: clk/rst (async active-high); mem_addr/mem_wdata/mem_we/mem_re/mem_be bus request;
//        mem_rdata/mem_ready/mem_fault completion; bd_we/bd_addr/bd_wdata backdoor full-word write.
// Optional feature macro: ARM7_MEM_SEQ_EN -- sequential accesses (last addr + 4, same direction)
//        use SEQ_WAIT wait states instead of WAIT_CYCLES. Undefined: every access uses WAIT_CYCLES.
module arm7_wait_mem #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 1,
    parameter int SEQ_WAIT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic                  mem_we,
    input  logic                  mem_re,
    input  logic [3:0]            mem_be,
    output logic [31:0]           mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_fault,
    input  logic                  bd_we,
    input  logic [ADDR_WIDTH-1:0] bd_addr,
    input  logic [31:0]           bd_wdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int MAXW  = (WAIT_CYCLES > SEQ_WAIT) ? WAIT_CYCLES : SEQ_WAIT;
    localparam int CW    = (MAXW < 1) ? 1 : $clog2(MAXW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  we_q, we_d;
    logic                  flt_q, flt_d;
    logic                  ready_q, ready_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  fault_q, fault_d;

`ifdef ARM7_MEM_SEQ_EN
    logic [29:0]           last_addr_q, last_addr_d;
    logic                  last_we_q, last_we_d;
    logic                  last_vld_q, last_vld_d;
`endif

    logic [31:0]           mem_q [DEPTH];

    // Access operands: taken straight from the bus for a zero-wait access
    // performed at the sampling edge, otherwise from the latched request.
    logic                  req;
    logic                  req_flt;
    logic [CW-1:0]         load_val;
    logic                  do_acc;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_be;
    logic                  acc_we;
    logic                  acc_flt;
    logic                  acc_wr;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^mem_addr[1:0];

    assign req     = mem_we | mem_re;
    assign req_flt = |mem_addr[31:ADDR_WIDTH+2];

    always_comb begin
        load_val = CW'(WAIT_CYCLES);
`ifdef ARM7_MEM_SEQ_EN
        if (last_vld_q && (mem_addr[31:2] == last_addr_q + 30'd1) && (mem_we == last_we_q)) begin
            load_val = CW'(SEQ_WAIT);
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        we_d      = we_q;
        flt_d     = flt_q;
        ready_d   = ready_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        do_acc    = 1'b0;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        acc_we    = we_q;
        acc_flt   = flt_q;
`ifdef ARM7_MEM_SEQ_EN
        last_addr_d = last_addr_q;
        last_we_d   = last_we_q;
        last_vld_d  = last_vld_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d    = mem_addr[ADDR_WIDTH+1:2];
                    wdata_d   = mem_wdata;
                    be_d      = mem_be;
                    we_d      = mem_we;
                    flt_d     = req_flt;
                    acc_addr  = mem_addr[ADDR_WIDTH+1:2];
                    acc_wdata = mem_wdata;
                    acc_be    = mem_be;
                    acc_we    = mem_we;
                    acc_flt   = req_flt;
                    if (load_val == '0) begin
                        do_acc  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = load_val;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // The edge that takes the count from 1 to 0 is the ready edge.
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    do_acc  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                ready_d = 1'b0;
                fault_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (do_acc) begin
            ready_d = 1'b1;
            fault_d = acc_flt;
            // Read happens before the write lands, so we&re returns the old word.
            rdata_d = acc_flt ? 32'd0 : mem_q[acc_addr];
`ifdef ARM7_MEM_SEQ_EN
            last_vld_d  = ~acc_flt;
            last_addr_d = 30'(acc_addr);
            last_we_d   = acc_we;
`endif
        end
    end

    // rst gate keeps a zero-wait write from landing while reset is held.
    assign acc_wr = do_acc & acc_we & ~acc_flt & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            flt_q   <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
`ifdef ARM7_MEM_SEQ_EN
            last_addr_q <= '0;
            last_we_q   <= 1'b0;
            last_vld_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            flt_q   <= flt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
`ifdef ARM7_MEM_SEQ_EN
            last_addr_q <= last_addr_d;
            last_we_q   <= last_we_d;
            last_vld_q  <= last_vld_d;
`endif
        end
    end

    // Array is not reset. Bus lanes are assigned after the backdoor so that on
    // a same-word collision the enabled bus lanes win and the backdoor fills the rest.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            mem_q[bd_addr] <= bd_wdata;
        end
        if (acc_wr) begin
            for (int n = 0; n < 4; n++) begin
                if (acc_be[n]) begin
                    mem_q[acc_addr][8*n +: 8] <= acc_wdata[8*n +: 8];
                end
            end
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_fault = fault_q;

endmodule
